tlp_wr_sink: RTL

TLP_WR_SINK -- requirements
Module: tlp_wr_sink

---
 rtl/tlp_wr_sink_pkg.sv | 29 ++
 rtl/tlp_wr_strb_gen.sv | 31 +++
 rtl/tlp_wr_sink.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tlp_wr_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module : tlp_wr_sink_pkg
// Brief  : Shared types and constants for the TLP memory-write to AXI sink.
// Rev    : 1.0  initial release
// ============================================================================
package tlp_wr_sink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } tlp_state_e;

    localparam int         FMT_WITH_DATA_BIT = 1;
    localparam logic [4:0] TYPE_MEM          = 5'b00000;
    localparam int         TLP_DATA_W        = 1024;
    localparam int         DW_W              = 32;

    // Index of the final beat for a payload of len DWs, dpb DWs per beat.
    function automatic logic [7:0] last_beat_idx(input logic [8:0] len, input int dpb);
        int n;
        n = (int'(len) + dpb - 1) / dpb;
        return 8'(n - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlp_wr_strb_gen.sv
`default_nettype none
// ============================================================================
// Module : tlp_wr_strb_gen
// Brief  : Byte strobes for beat k of a burst carrying i_len valid DWs.
// Rev    : 1.0  initial release
// ============================================================================
module tlp_wr_strb_gen
    import tlp_wr_sink_pkg::*;
#(
    parameter int BEAT_W = 128
) (
    input  logic [8:0]          i_len,
    input  logic [7:0]          i_beat,
    output logic [BEAT_W/8-1:0] o_strb
);

    localparam int c_DPB      = BEAT_W / DW_W;
    localparam int c_DW_BYTES = DW_W / 8;

    genvar d;
    generate
        for (d = 0; d < c_DPB; d++) begin : g_dw
            logic [15:0] w_dw_idx;
            assign w_dw_idx = 16'(i_beat) * 16'(c_DPB) + 16'(d);
            assign o_strb[d*c_DW_BYTES +: c_DW_BYTES] =
                (w_dw_idx < 16'(i_len)) ? {c_DW_BYTES{1'b1}} : {c_DW_BYTES{1'b0}};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/tlp_wr_sink.sv
`default_nettype none
// ============================================================================
// Module : tlp_wr_sink
// Brief  : Turns received PCIe memory-write TLPs into single AXI write bursts.
//          Optional macro TLP_WR_SINK_STATS_EN adds drop_cnt_o.
// Rev    : 1.0  initial release
// ============================================================================
module tlp_wr_sink
    import tlp_wr_sink_pkg::*;
#(
    parameter int BEAT_W = 128,
    parameter int MAX_DW = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tlp_valid_i,
    output logic                  tlp_ready_o,
    input  logic [2:0]            tlp_fmt_i,
    input  logic [4:0]            tlp_type_i,
    input  logic [8:0]            tlp_length_i,
    input  logic [31:0]           tlp_addr_i,
    input  logic [TLP_DATA_W-1:0] tlp_data_i,
    output logic [31:0]           awaddr_o,
    output logic [7:0]            awlen_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [BEAT_W-1:0]     wdata_o,
    output logic [BEAT_W/8-1:0]   wstrb_o,
    output logic                  wlast_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o,
    output logic                  err_o
`ifdef TLP_WR_SINK_STATS_EN
    ,
    output logic [15:0]           drop_cnt_o
`endif
);

    localparam int c_DPB   = BEAT_W / DW_W;
    localparam int c_NB    = TLP_DATA_W / BEAT_W;
    localparam int c_IDX_W = (c_NB > 1) ? $clog2(c_NB) : 1;

    tlp_state_e                r_state;
    tlp_state_e                w_state_nxt;
    logic                      r_live;
    logic [31:0]               r_addr;
    logic [8:0]                r_len;
    logic [7:0]                r_last_beat;
    logic [7:0]                r_beat;
    logic [TLP_DATA_W-1:0]     r_data;
    logic                      r_err;

    logic                      w_is_wr;
    logic                      w_accept;
    logic                      w_drop;
    logic                      w_clamp;
    logic [8:0]                w_len_eff;
    logic                      w_final_beat;
    logic [BEAT_W/8-1:0]       w_strb;
    logic [BEAT_W-1:0]         w_beats [c_NB];
    logic                      w_unused_fmt;

    // Only fmt[1] (payload present) distinguishes a write from a read.
    assign w_unused_fmt = ^{tlp_fmt_i[2], tlp_fmt_i[0]};

    assign w_is_wr      = tlp_fmt_i[FMT_WITH_DATA_BIT] && (tlp_type_i == TYPE_MEM);
    assign w_accept     = tlp_valid_i && tlp_ready_o;
    assign w_drop       = w_accept && (!w_is_wr || (tlp_length_i == 9'd0));
    assign w_clamp      = tlp_length_i > 9'(MAX_DW);
    assign w_len_eff    = w_clamp ? 9'(MAX_DW) : tlp_length_i;
    assign w_final_beat = (r_beat == r_last_beat);

    always_comb begin
        w_state_nxt = r_state;
        tlp_ready_o = 1'b0;
        awvalid_o   = 1'b0;
        wvalid_o    = 1'b0;
        bready_o    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                tlp_ready_o = r_live;
                if (w_accept && !w_drop) begin
                    w_state_nxt = ST_AW;
                end
            end
            ST_AW: begin
                awvalid_o = 1'b1;
                if (awready_i) begin
                    w_state_nxt = ST_W;
                end
            end
            ST_W: begin
                wvalid_o = 1'b1;
                if (wready_i && w_final_beat) begin
                    w_state_nxt = ST_B;
                end
            end
            ST_B: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_live      <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_last_beat <= '0;
            r_beat      <= '0;
            r_data      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            // Drops and clamped lengths both report one cycle after acceptance.
            r_err   <= w_accept && (w_drop || w_clamp);
            if (w_accept) begin
                r_addr      <= tlp_addr_i;
                r_len       <= w_len_eff;
                r_last_beat <= last_beat_idx(w_len_eff, c_DPB);
                r_data      <= tlp_data_i;
                r_beat      <= '0;
            end else if ((r_state == ST_W) && wready_i && !w_final_beat) begin
                r_beat <= r_beat + 8'd1;
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < c_NB; i++) begin : g_beat
            assign w_beats[i] = r_data[i*BEAT_W +: BEAT_W];
        end
    endgenerate

    tlp_wr_strb_gen #(
        .BEAT_W (BEAT_W)
    ) u_strb_gen (
        .i_len  (r_len),
        .i_beat (r_beat),
        .o_strb (w_strb)
    );

    // Payload outputs read as zero outside the state that presents them.
    assign awaddr_o = awvalid_o ? r_addr      : 32'd0;
    assign awlen_o  = awvalid_o ? r_last_beat : 8'd0;
    assign wdata_o  = wvalid_o  ? w_beats[r_beat[c_IDX_W-1:0]] : '0;
    assign wstrb_o  = wvalid_o  ? w_strb      : '0;
    assign wlast_o  = wvalid_o && w_final_beat;
    assign err_o    = r_err || (bready_o && bvalid_i && (bresp_i != 2'b00));

`ifdef TLP_WR_SINK_STATS_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`else
    // Build without drop statistics: no counter, same err_o behaviour.
`endif

endmodule
`default_nettype wire
